// File: rtl/reg_write_queue_pkg.sv
// Shared widths and defaults for the register writeback queue.
package reg_write_queue_pkg;
   localparam int REG_DATA_WIDTH = 64;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int WBQ_DEPTH      = 4;
endpackage

// File: rtl/reg_write_queue_bypass.sv
// Youngest-first match of one lookup address against every pending queue entry.
module reg_write_queue_bypass
   import reg_write_queue_pkg::*;
#(
   parameter int DATA_WIDTH = REG_DATA_WIDTH,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int DEPTH      = WBQ_DEPTH,
   parameter int PTR_W      = $clog2(DEPTH)
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [ADDR_WIDTH-1:0] i_ent_addr [DEPTH],
   input  logic [DATA_WIDTH-1:0] i_ent_data [DEPTH],
   input  logic [DEPTH-1:0]      i_ent_valid,
   input  logic [PTR_W-1:0]      i_wr_ptr,
   output logic                  o_hit,
   output logic [DATA_WIDTH-1:0] o_data
);
   logic [DEPTH-1:0] w_match;
   logic [PTR_W-1:0] w_idx;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_match
         assign w_match[gi] = i_ent_valid[gi] && (i_ent_addr[gi] == i_addr) && (i_addr != '0);
      end
   endgenerate

   // Walk oldest to youngest so the youngest match is the last assignment.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      w_idx  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         w_idx = i_wr_ptr - PTR_W'(k + 1);
         if (w_match[w_idx]) begin
            o_hit  = 1'b1;
            o_data = i_ent_data[w_idx];
         end
      end
   end
endmodule

// File: rtl/reg_write_queue.sv
// Writeback FIFO feeding the register file write port, with two bypass lookups.
module reg_write_queue
   import reg_write_queue_pkg::*;
#(
   parameter int DATA_WIDTH = REG_DATA_WIDTH,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int DEPTH      = WBQ_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_WIDTH-1:0]      in_addr,
   input  logic [DATA_WIDTH-1:0]      in_data,
   input  logic                       rf_ready,
   output logic                       RegWrite,
   output logic [ADDR_WIDTH-1:0]      write_reg_addr,
   output logic [DATA_WIDTH-1:0]      write_reg_data,
   input  logic [ADDR_WIDTH-1:0]      byp_addr_1,
   input  logic [ADDR_WIDTH-1:0]      byp_addr_2,
   output logic                       byp_hit_1,
   output logic                       byp_hit_2,
   output logic [DATA_WIDTH-1:0]      byp_data_1,
   output logic [DATA_WIDTH-1:0]      byp_data_2,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0]      r_valid;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_enq;
   logic                  w_deq;

   assign in_ready = (r_count < CNT_W'(DEPTH));
   assign RegWrite = (r_count != '0);
   // x0 requests complete the handshake but are never stored.
   assign w_enq    = in_valid && in_ready && (in_addr != '0);
   assign w_deq    = RegWrite && rf_ready;

   assign write_reg_addr = RegWrite ? r_addr[r_rd_ptr] : '0;
   assign write_reg_data = RegWrite ? r_data[r_rd_ptr] : '0;
   assign count          = r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
         for (int i = 0; i < DEPTH; i++) begin
            if (w_enq && (r_wr_ptr == PTR_W'(i)))
               r_valid[i] <= 1'b1;
            else if (w_deq && (r_rd_ptr == PTR_W'(i)))
               r_valid[i] <= 1'b0;
         end
      end
   end

   // Payload storage is qualified by r_valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_addr[r_wr_ptr] <= in_addr;
         r_data[r_wr_ptr] <= in_data;
      end
   end

   reg_write_queue_bypass #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_W      (PTR_W)
   ) u_byp_1 (
      .i_addr      (byp_addr_1),
      .i_ent_addr  (r_addr),
      .i_ent_data  (r_data),
      .i_ent_valid (r_valid),
      .i_wr_ptr    (r_wr_ptr),
      .o_hit       (byp_hit_1),
      .o_data      (byp_data_1)
   );

   reg_write_queue_bypass #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_W      (PTR_W)
   ) u_byp_2 (
      .i_addr      (byp_addr_2),
      .i_ent_addr  (r_addr),
      .i_ent_data  (r_data),
      .i_ent_valid (r_valid),
      .i_wr_ptr    (r_wr_ptr),
      .o_hit       (byp_hit_2),
      .o_data      (byp_data_2)
   );
endmodule
